// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 shift-add multiplier and restoring divider owning Hi/Lo.
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU report IllegalOp.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic             IllegalOp,
  output logic [WIDTH-1:0] HiData,
  output logic [WIDTH-1:0] LoData
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_MULT = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_DIVU = 3'd3;
  localparam logic [2:0] OP_MADD = 3'd4;
  localparam logic [2:0] OP_MSUB = 3'd5;
  localparam logic [2:0] OP_MTHI = 3'd6;
  localparam logic [2:0] OP_MTLO = 3'd7;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic fix_ph;
  logic busy_d, done_d, dbz_d, ill_d;

  logic [WIDTH-1:0] hi, lo, m, w_hi, w_lo, s_a;
  logic [2:0] op_q;
  logic neg_q;
  logic s_vld, s_mthi, s_mtlo, s_dbz, s_ill;

  logic accept, is_div, is_mov, is_sgn, sa, sb;
  logic dbz_req, ill_req, go_iter, go_single;
  logic [WIDTH-1:0] mag_a, mag_b, step_hi, step_lo;
  logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
  logic neg_r, div_q, ge;
  logic [WIDTH:0] sh;
  logic [WIDTH-1:0] rem_sub;
  assign div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);
`endif

  assign HiData = hi;
  assign LoData = lo;

  always_comb begin
    is_div = (Op == OP_DIV) || (Op == OP_DIVU);
    is_mov = (Op == OP_MTHI) || (Op == OP_MTLO);
    is_sgn = (Op == OP_MULT) || (Op == OP_DIV) ||
             (Op == OP_MADD) || (Op == OP_MSUB);
    sa = is_sgn & OperandA[WIDTH-1];
    sb = is_sgn & OperandB[WIDTH-1];
    mag_a = sa ? -OperandA : OperandA;
    mag_b = sb ? -OperandB : OperandB;
    accept = Start && (state == IDLE);
`ifdef MULDIV_DIV_EN
    dbz_req = is_div && (OperandB == '0);
    ill_req = 1'b0;
`else
    dbz_req = 1'b0;
    ill_req = is_div;
`endif
    go_iter = accept && !is_mov && !dbz_req && !ill_req;
    go_single = accept && !go_iter;
  end

  // One iteration step: shift-add for multiply, restoring step for divide
  always_comb begin
    sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, m} : '0);
    step_hi = sum[WIDTH:1];
    step_lo = {sum[0], w_lo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    sh = {w_hi, w_lo[WIDTH-1]};
    ge = sh >= {1'b0, m};
    rem_sub = sh[WIDTH-1:0] - m;
    if (div_q) begin
      step_hi = ge ? rem_sub : sh[WIDTH-1:0];
      step_lo = {w_lo[WIDTH-2:0], ge};
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
      cnt <= '0;
      fix_ph <= 1'b0;
      Busy <= 1'b0;
      Done <= 1'b0;
      DivByZero <= 1'b0;
      IllegalOp <= 1'b0;
    end else begin
      state <= state_nx;
      Busy <= busy_d;
      Done <= done_d;
      DivByZero <= dbz_d;
      IllegalOp <= ill_d;
      fix_ph <= (state == FIX) && !fix_ph;
      if (go_iter) cnt <= CW'(WIDTH - 1);
      else if (state == ITER && cnt != '0) cnt <= cnt - CW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (go_iter) state_nx = ITER;
      ITER: if (cnt == '0) state_nx = FIX;
      FIX:  if (fix_ph) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state != IDLE) && (state_nx != IDLE);
    done_d = s_vld || (state == FIX && fix_ph);
    dbz_d = s_vld && s_dbz;
    ill_d = s_vld && s_ill;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      hi <= '0;
      lo <= '0;
      m <= '0;
      w_hi <= '0;
      w_lo <= '0;
      op_q <= OP_MULT;
      neg_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_r <= 1'b0;
`endif
      s_vld <= 1'b0;
      s_mthi <= 1'b0;
      s_mtlo <= 1'b0;
      s_dbz <= 1'b0;
      s_ill <= 1'b0;
      s_a <= '0;
    end else begin
      // Single-cycle ops complete one edge after acceptance
      s_vld <= go_single;
      s_mthi <= go_single && (Op == OP_MTHI);
      s_mtlo <= go_single && (Op == OP_MTLO);
      s_dbz <= go_single && dbz_req;
      s_ill <= go_single && ill_req;
      s_a <= OperandA;
      if (s_mthi) hi <= s_a;
      if (s_mtlo) lo <= s_a;
      unique case (state)
        IDLE: if (go_iter) begin
          op_q <= Op;
          neg_q <= sa ^ sb;
`ifdef MULDIV_DIV_EN
          neg_r <= sa;
`endif
          w_hi <= '0;
          m <= is_div ? mag_b : mag_a;
          w_lo <= is_div ? mag_a : mag_b;
        end
        ITER: begin
          w_hi <= step_hi;
          w_lo <= step_lo;
        end
        FIX: begin
          if (!fix_ph) begin
`ifdef MULDIV_DIV_EN
            if (div_q) begin
              if (neg_q) w_lo <= -w_lo;
              if (neg_r) w_hi <= -w_hi;
            end else
`endif
            if (neg_q) {w_hi, w_lo} <= -{w_hi, w_lo};
          end else begin
            unique case (1'b1)
              op_q == OP_MADD: {hi, lo} <= {hi, lo} + {w_hi, w_lo};
              op_q == OP_MSUB: {hi, lo} <= {hi, lo} - {w_hi, w_lo};
              default:         {hi, lo} <= {w_hi, w_lo};
            endcase
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: vector table, corner sequences and random ops for muldiv_unit.
// Expected Hi/Lo come from a plain-arithmetic model of the architectural ops.
module tb_muldiv_unit;
  localparam int W = 32;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic Start = 1'b0;
  logic [2:0] Op = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic Busy, Done, DivByZero, IllegalOp;
  logic [W-1:0] HiData, LoData;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mhi = '0;
  logic [W-1:0] mlo = '0;
  logic [W-1:0] e_hi, e_lo;
  logic e_dbz, e_ill;
  int e_lat;

  typedef struct {
    logic [2:0] op;
    logic [W-1:0] a, b, hi, lo;
    logic dbz, ill;
  } vec_t;

  vec_t tbl[12];

  muldiv_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op),
    .OperandA(A), .OperandB(B),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .IllegalOp(IllegalOp),
    .HiData(HiData), .LoData(LoData)
  );

  always #5 Clk = ~Clk;

  task automatic check(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  // Architectural result of one op applied to the model Hi/Lo
  task automatic predict(input logic [2:0] op, input logic [W-1:0] a, b);
    longint sa, sb;
    logic [63:0] acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    acc = {mhi, mlo};
    e_dbz = 1'b0;
    e_ill = 1'b0;
    e_lat = W + 2;
    case (op)
      3'd0: acc = 64'(sa * sb);
      3'd1: acc = {32'b0, a} * {32'b0, b};
      3'd4: acc = acc + 64'(sa * sb);
      3'd5: acc = acc - 64'(sa * sb);
      3'd6: begin acc[63:32] = a; e_lat = 1; end
      3'd7: begin acc[31:0] = a; e_lat = 1; end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == '0) begin
          e_dbz = 1'b1;
          e_lat = 1;
        end else if (op == 3'd2) begin
          acc = {32'(sa % sb), 32'(sa / sb)};
        end else begin
          acc = {a % b, a / b};
        end
`else
        e_ill = 1'b1;
        e_lat = 1;
`endif
      end
    endcase
    e_hi = acc[63:32];
    e_lo = acc[31:0];
  endtask

  // Issue at a negedge; returns at the negedge of the Done cycle
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, b,
                        input logic [W-1:0] xh, xl, input logic xd, xi,
                        input int lat, input int inj, input string nm);
    bit t_ok;
    bit eb, ed;
    int fc;
    logic fb, fd;
    t_ok = 1'b1;
    fc = -1;
    fb = 1'b0;
    fd = 1'b0;
    Start = 1'b1;
    Op = op;
    A = a;
    B = b;
    @(posedge Clk);
    for (int c = 0; c <= lat; c++) begin
      @(negedge Clk);
      eb = (lat > 1) && (c >= 1) && (c < lat);
      ed = (c == lat);
      if (Busy !== eb || Done !== ed ||
          (c < lat && (HiData !== mhi || LoData !== mlo))) begin
        if (t_ok) begin
          fc = c;
          fb = Busy;
          fd = Done;
        end
        t_ok = 1'b0;
      end
      Start = 1'b0;
      if (c == inj) begin
        Start = 1'b1;
        Op = 3'd7;
        A = 32'h55;
      end
    end
    check(t_ok, $sformatf("%s timing: cycle %0d busy=%b done=%b (or Hi/Lo moved early), required busy/done per latency %0d",
                          nm, fc, fb, fd, lat));
    check(HiData === xh && LoData === xl && DivByZero === xd && IllegalOp === xi,
          $sformatf("%s result: hi=%h lo=%h dbz=%b ill=%b, required hi=%h lo=%h dbz=%b ill=%b",
                    nm, HiData, LoData, DivByZero, IllegalOp, xh, xl, xd, xi));
    mhi = xh;
    mlo = xl;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    tbl[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 1'b0};
    tbl[1]  = '{3'd1, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 1'b0, 1'b0};
    tbl[2]  = '{3'd6, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFA, 1'b0, 1'b0};
    tbl[3]  = '{3'd7, 32'd10, 32'd0, 32'd0, 32'd10, 1'b0, 1'b0};
    tbl[4]  = '{3'd4, 32'd4, 32'd5, 32'd0, 32'd30, 1'b0, 1'b0};
    tbl[5]  = '{3'd5, 32'd7, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, 1'b0};
`ifdef MULDIV_DIV_EN
    tbl[6]  = '{3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0};
    tbl[7]  = '{3'd3, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 1'b0};
    tbl[8]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 1'b0};
    tbl[11] = '{3'd2, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 1'b0};
`else
    tbl[6]  = '{3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, 1'b1};
    tbl[7]  = '{3'd3, 32'hFFFFFFFF, 32'h10, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, 1'b1};
    tbl[8]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, 1'b1};
    tbl[11] = '{3'd2, 32'd5, 32'd0, 32'h11, 32'h22, 1'b0, 1'b1};
`endif
    tbl[9]  = '{3'd6, 32'h11, 32'd0, 32'h11, tbl[8].lo, 1'b0, 1'b0};
    tbl[10] = '{3'd7, 32'h22, 32'd0, 32'h11, 32'h22, 1'b0, 1'b0};

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check(Busy === 1'b0 && Done === 1'b0 && DivByZero === 1'b0 &&
          IllegalOp === 1'b0 && HiData === '0 && LoData === '0,
          $sformatf("reset state: busy=%b done=%b dbz=%b ill=%b hi=%h lo=%h, required all 0",
                    Busy, Done, DivByZero, IllegalOp, HiData, LoData));
    Rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      predict(tbl[i].op, tbl[i].a, tbl[i].b);
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo,
             tbl[i].dbz, tbl[i].ill, e_lat, -1, $sformatf("vec%0d", i));
    end

    // MTLO pulsed mid-multiply is ignored; next op issued in the Done cycle
    run_op(3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0, W + 2, 5, "ignore_start");
    run_op(3'd1, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b0, W + 2, -1, "done_cycle_issue");

    // Reset in the middle of a multiply
    Start = 1'b1;
    Op = 3'd0;
    A = 32'd3;
    B = 32'd4;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    check(Busy === 1'b0 && Done === 1'b0 && DivByZero === 1'b0 &&
          IllegalOp === 1'b0 && HiData === '0 && LoData === '0,
          $sformatf("midop reset: busy=%b done=%b dbz=%b ill=%b hi=%h lo=%h, required all 0",
                    Busy, Done, DivByZero, IllegalOp, HiData, LoData));
    Rst = 1'b1;
    mhi = '0;
    mlo = '0;
    run_op(3'd0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0, W + 2, -1, "after_reset");

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [W-1:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      predict(op, a, b);
      run_op(op, a, b, e_hi, e_lo, e_dbz, e_ill, e_lat, -1,
             $sformatf("rand%0d op%0d a=%h b=%h", i, op, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
